// File: rtl/contador_ctrl_if.sv
// Button-level inputs and count/display outputs of the counter sequencer.
interface contador_ctrl_if;
  logic        up;
  logic        down;
  logic        clr;
  logic [15:0] bcd;
  logic        step;
  logic        wrap;
  logic        dir;

  // Drives buttons, observes the count.
  modport master (
    output up, down, clr,
    input  bcd, step, wrap, dir
  );

  // The sequencer itself.
  modport slave (
    input  up, down, clr,
    output bcd, step, wrap, dir
  );
endinterface

// File: rtl/contador_ctrl.sv
// Sequencing controller for a 0-9999 BCD counter: turns debounced button levels
// into single steps with hold-to-auto-repeat, and holds the 4-digit count.
module contador_ctrl #(
  parameter int unsigned HOLD_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter int unsigned TW            = 26
) (
  input  logic           clk,
  input  logic           reset,
  contador_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHold   = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;
  localparam logic [1:0] StLock   = 2'd3;

  localparam logic [TW-1:0] HoldLast   = TW'(HOLD_DELAY - 1);
  localparam logic [TW-1:0] RepeatLast = TW'(REPEAT_PERIOD - 1);

  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic          r_up_q;
  logic          r_dn_q;
  logic [15:0]   r_bcd;
  logic          r_step;
  logic          r_wrap;
  logic          r_dir;

  logic [1:0]    w_state_d;
  logic [TW-1:0] w_timer_d;
  logic          w_do_step;
  logic          w_step_up;
  logic          w_wrap_d;
  logic          w_rise_up;
  logic          w_rise_dn;
  logic          w_active;
  logic          w_other;
  logic [15:0]   w_bcd_inc;
  logic [15:0]   w_bcd_dec;
  logic          w_carry;
  logic          w_borrow;

  assign w_rise_up = bus.up & ~r_up_q;
  assign w_rise_dn = bus.down & ~r_dn_q;
  // The button that started the current hold is the one matching the last direction.
  assign w_active  = r_dir ? bus.up : bus.down;
  assign w_other   = r_dir ? bus.down : bus.up;

  // Per-digit BCD increment and decrement with ripple carry/borrow.
  always_comb begin
    w_bcd_inc = r_bcd;
    w_bcd_dec = r_bcd;
    w_carry   = 1'b1;
    w_borrow  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_bcd[4*i +: 4] == 4'd9) begin
          w_bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          w_carry = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_bcd[4*i +: 4] == 4'd0) begin
          w_bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          w_bcd_dec[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
          w_borrow = 1'b0;
        end
      end
    end
  end

  // Next-state, timer and step decision; clr overrides everything.
  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_do_step = 1'b0;
    w_step_up = r_dir;
    if (bus.clr) begin
      w_state_d = StIdle;
      w_timer_d = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.up && bus.down) begin
            w_state_d = StLock;
          end else if (w_rise_up) begin
            w_do_step = 1'b1;
            w_step_up = 1'b1;
            w_timer_d = '0;
            w_state_d = StHold;
          end else if (w_rise_dn) begin
            w_do_step = 1'b1;
            w_step_up = 1'b0;
            w_timer_d = '0;
            w_state_d = StHold;
          end
        end
        StHold, StRepeat: begin
          if (!w_active) begin
            w_state_d = StIdle;
            w_timer_d = '0;
          end else if (w_other) begin
            w_state_d = StLock;
            w_timer_d = '0;
          end else if (r_timer == ((r_state == StHold) ? HoldLast : RepeatLast)) begin
            w_do_step = 1'b1;
            w_timer_d = '0;
            w_state_d = StRepeat;
          end else begin
            w_timer_d = r_timer + 1'b1;
          end
        end
        StLock: begin
          if (!bus.up && !bus.down) w_state_d = StIdle;
        end
        default: begin
          w_state_d = StIdle;
          w_timer_d = '0;
        end
      endcase
    end
    w_wrap_d = w_do_step & (w_step_up ? (r_bcd == 16'h9999) : (r_bcd == 16'h0000));
  end

  // State, edge-detect history, count and registered output pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_up_q  <= 1'b0;
      r_dn_q  <= 1'b0;
      r_bcd   <= 16'h0000;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
      r_dir   <= 1'b1;
    end else begin
      r_up_q  <= bus.up;
      r_dn_q  <= bus.down;
      r_state <= w_state_d;
      r_timer <= w_timer_d;
      r_step  <= w_do_step;
      r_wrap  <= w_wrap_d;
      if (w_do_step) r_dir <= w_step_up;
      if (bus.clr) begin
        r_bcd <= 16'h0000;
      end else if (w_do_step) begin
        r_bcd <= w_step_up ? w_bcd_inc : w_bcd_dec;
      end
    end
  end

  assign bus.bcd  = r_bcd;
  assign bus.step = r_step;
  assign bus.wrap = r_wrap;
  assign bus.dir  = r_dir;

endmodule

// File: tb/tb_contador_ctrl.sv
// Randomized and directed bench for contador_ctrl against an integer-count model.
module tb_contador_ctrl;
  localparam int unsigned HD = 8;
  localparam int unsigned RP = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  contador_ctrl_if bus ();

  contador_ctrl #(
    .HOLD_DELAY   (HD),
    .REPEAT_PERIOD(RP),
    .TW           (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: count as an integer, hold behaviour as "edges until next step".
  int m_count;
  int m_mode;     // 0 idle, 1 holding a button, 2 locked
  bit m_held_up;
  int m_remain;
  bit m_pu, m_pd;
  bit m_step, m_wrap, m_dir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_count = 0; m_mode = 0; m_held_up = 1'b1; m_remain = 0;
    m_pu = 0; m_pd = 0; m_step = 0; m_wrap = 0; m_dir = 1;
  endtask

  task automatic model_step(input bit upw);
    m_step = 1;
    m_dir  = upw;
    if (upw) begin
      if (m_count == 9999) begin m_count = 0; m_wrap = 1; end
      else m_count++;
    end else begin
      if (m_count == 0) begin m_count = 9999; m_wrap = 1; end
      else m_count--;
    end
  endtask

  task automatic model_edge(input bit u, input bit d, input bit c);
    bit act, oth;
    m_step = 0;
    m_wrap = 0;
    if (c) begin
      m_count = 0;
      m_mode  = 0;
    end else begin
      case (m_mode)
        0: begin
          if (u && d) m_mode = 2;
          else if (u && !m_pu) begin
            model_step(1'b1); m_mode = 1; m_held_up = 1; m_remain = HD;
          end else if (d && !m_pd) begin
            model_step(1'b0); m_mode = 1; m_held_up = 0; m_remain = HD;
          end
        end
        1: begin
          act = m_held_up ? u : d;
          oth = m_held_up ? d : u;
          if (!act) m_mode = 0;
          else if (oth) m_mode = 2;
          else begin
            m_remain--;
            if (m_remain == 0) begin
              model_step(m_held_up);
              m_remain = RP;
            end
          end
        end
        default: if (!u && !d) m_mode = 0;
      endcase
    end
    m_pu = u;
    m_pd = d;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare just after.
  task automatic cyc(input bit u, input bit d, input bit c);
    @(negedge clk);
    bus.up = u; bus.down = d; bus.clr = c;
    @(posedge clk);
    model_edge(u, d, c);
    #1;
    check("bcd",  32'(bus.bcd),  32'(to_bcd(m_count)));
    check("step", 32'(bus.step), 32'(m_step));
    check("wrap", 32'(bus.wrap), 32'(m_wrap));
    check("dir",  32'(bus.dir),  32'(m_dir));
  endtask

  task automatic hold(input bit u, input bit d, input bit c, input int n);
    for (int i = 0; i < n; i++) cyc(u, d, c);
  endtask

  initial begin
    bus.up = 0; bus.down = 0; bus.clr = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd",  32'(bus.bcd),  32'h0000);
    check("rst_step", 32'(bus.step), 32'd0);
    check("rst_wrap", 32'(bus.wrap), 32'd0);
    check("rst_dir",  32'(bus.dir),  32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Short press: exactly one up-step.
    hold(1, 0, 0, 3);
    hold(0, 0, 0, 2);
    check("pulse_one", 32'(bus.bcd), 32'h0001);

    // Wrap down from 0000, then wrap up from 9999.
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    check("wrap_dn_bcd", 32'(bus.bcd), 32'h9999);
    check("wrap_dn_flag", 32'(bus.wrap), 32'd1);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("wrap_up_bcd", 32'(bus.bcd), 32'h0000);
    check("wrap_up_flag", 32'(bus.wrap), 32'd1);
    hold(0, 0, 0, 2);

    // Held up for 20 cycles: steps at 0, 8, 12, 16.
    hold(1, 0, 0, 20);
    hold(0, 0, 0, 3);
    check("auto_rep", 32'(bus.bcd), 32'h0004);

    // Reach 0100 by auto-repeat, then borrow across digits going down.
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    hold(1, 0, 0, 401);
    hold(0, 0, 0, 2);
    check("load_100", 32'(bus.bcd), 32'h0100);
    cyc(0, 1, 0);
    check("borrow", 32'(bus.bcd), 32'h0099);
    cyc(0, 0, 0);
    hold(0, 1, 0, 13);
    hold(0, 0, 0, 2);

    // Other button during hold locks out steps until both are released.
    hold(1, 0, 0, 5);
    hold(1, 1, 0, 10);
    hold(0, 1, 0, 3);
    hold(0, 0, 0, 2);
    hold(1, 1, 0, 4);
    hold(0, 0, 0, 2);

    // clr while repeating; button still held when clr falls gives no step.
    hold(1, 0, 0, 14);
    hold(1, 0, 1, 4);
    hold(1, 0, 0, 3);
    check("clr_hold", 32'(bus.bcd), 32'h0000);
    hold(0, 0, 0, 2);
    cyc(1, 0, 0);
    check("clr_after", 32'(bus.bcd), 32'h0001);
    hold(0, 0, 0, 2);

    // Asynchronous reset in the middle of repeat.
    hold(1, 0, 0, 14);
    @(negedge clk);
    bus.up = 0;
    #2 reset = 1'b0;
    #1;
    check("async_rst", 32'(bus.bcd), 32'h0000);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    hold(0, 0, 0, 2);
    cyc(1, 0, 0);
    check("post_rst", 32'(bus.bcd), 32'h0001);
    hold(0, 0, 0, 2);

    // Randomized segments of held button combinations.
    for (int s = 0; s < 150; s++) begin
      bit u, d, c;
      int len;
      u   = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 2) == 0);
      c   = ($urandom_range(0, 7) == 0);
      len = int'($urandom_range(1, 20));
      hold(u, d, c, len);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/contador_ctrl.md
Name: contador_ctrl

Overview:
- Sequencing controller for the 0-9999 counter.
- Takes already-debounced push-button levels (up, down, clear) and converts them into counter steps, with hold-to-auto-repeat.
- Holds the 4-digit BCD count and drives the display path.
- Sits between the per-button debouncers and the 7-segment multiplexer.

Parameters:
- HOLD_DELAY, 50000000, cycles a button must stay held after its first step before auto-repeat starts.
- REPEAT_PERIOD, 10000000, cycles between auto-repeat steps.
- TW, 26, timer width in bits; must satisfy 2^TW > max(HOLD_DELAY, REPEAT_PERIOD).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- up  input  1  debounced level, synchronous to clk; 1 = pressed.
- down  input  1  debounced level, synchronous to clk; 1 = pressed.
- clr  input  1  debounced level, synchronous to clk; 1 = clear.
- bcd  output  16  count as 4 BCD digits; [15:12] thousands ... [3:0] units.
- step  output  1  one-cycle pulse, high in the cycle bcd takes a new stepped value.
- wrap  output  1  one-cycle pulse coincident with step when the count wraps (9999->0000 or 0000->9999).
- dir  output  1  direction of the last step; 1 = up, 0 = down.

Behaviour:
- Reset (reset=0, asynchronous):
  - bcd=16'h0000, step=0, wrap=0, dir=1.
  - state=IDLE, timer=0, up_q=0, dn_q=0.
- Edge detect: up_q and dn_q register up and down every cycle, in every state including during clr.
  - rise_up = up & ~up_q; rise_dn = down & ~dn_q.
- Priority: clr > (up & down) > up > down.
- clr=1 (synchronous, level):
  - bcd<=0000, state<=IDLE, timer<=0, step=0, wrap=0.
  - No steps while clr=1.
  - A button still held when clr falls is not a new edge, so it produces no step.
- FSM states: IDLE, HOLD, REPEAT, LOCK.
- IDLE:
  - up & down both 1 -> LOCK, no step.
  - rise_up -> one up-step, dir<=1, timer<=0, -> HOLD.
  - Else rise_dn -> one down-step, dir<=0, timer<=0, -> HOLD.
- HOLD:
  - Active button released -> IDLE, no step.
  - Other button also pressed -> LOCK, no step.
  - timer==HOLD_DELAY-1 -> one step in dir, timer<=0, -> REPEAT.
  - Else timer++.
- REPEAT:
  - Release and other-button rules as in HOLD.
  - timer==REPEAT_PERIOD-1 -> one step in dir, timer<=0, stay in REPEAT.
  - Else timer++.
- LOCK: no steps; -> IDLE only when up=0 and down=0.
- Latency:
  - Button rise sampled at edge n -> bcd updated and step=1 at edge n (registered outputs visible from n+1).
  - Held button: next step HOLD_DELAY cycles after the first, then every REPEAT_PERIOD cycles.
- BCD arithmetic:
  - Per-digit increment 9->0 with carry; per-digit decrement 0->9 with borrow.
  - Digits never leave 0-9.
  - 9999+1 -> 0000 with wrap=1; 0000-1 -> 9999 with wrap=1.
- step/wrap: high exactly one cycle per step, otherwise 0.
- Reset asserted mid-hold or mid-repeat: immediate return to reset values; after release no step until a new rising edge.

Test Plan:
(bench parameters: HOLD_DELAY=8, REPEAT_PERIOD=4)
- Reset released, up pulsed 3 cycles -> bcd 0000->0001, single step pulse, wrap=0, dir=1.
- Preload 9999 via up-steps (or clr followed by down pulse -> 9999 with wrap=1); then up pulse -> bcd=0000, wrap=1 with step.
- up held 20 cycles from 0000 -> steps at cycles 0, 8, 12, 16; bcd=0004; release -> IDLE, no further steps.
- bcd=0100, down pulse -> 0099; down held -> 0099, then 0098 after 8 cycles, 0097 four cycles later (borrow across digits correct).
- up held, then down asserted in HOLD -> no steps until both released; down rising edge in the same cycle as up -> LOCK, no step.
- clr asserted while up held in REPEAT -> bcd=0000, no steps; clr falls with up still high -> no step; up release then press -> bcd=0001.
- Reset (reset=0) during REPEAT -> bcd=0000 immediately, without waiting for a clk edge.
